// File: rtl/ps2_input_ctrl.sv
// PS/2 keyboard front end: filters the raw lines, frames 11-bit packets, decodes
// make/break/extended prefixes and turns held keys into paddle steps and a play mode.
module ps2_input_ctrl #(
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT       = 25000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       left_step,
    output logic       right_step,
    output logic [1:0] mode,
    output logic       mode_stb,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    function automatic logic odd_ones9(input logic [8:0] bits);
        return ^bits;
    endfunction

    function automatic logic [1:0] key_mode(input logic [7:0] code);
        case (code)
            8'h16:   return 2'd1;
            8'h1E:   return 2'd2;
            8'h26:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [FILTER_LEN-1:0] clk_sh_r, dat_sh_r;
    logic                  clk_filt_r, dat_filt_r, clk_prev_r;
    logic                  fall_s;
    frame_state_t          state_r, state_nxt_s;
    logic [2:0]            bitcnt_r;
    logic [7:0]            shift_r;
    logic                  parity_r;
    logic [TW-1:0]         idle_cnt_r;
    logic                  timeout_s, frame_ok_s;
    logic [7:0]            scan_code_r;
    logic                  scan_valid_r, frame_err_r;
    logic                  brk_r, ext_r, held_left_r, held_right_r;
    logic [1:0]            mode_r;
    logic                  mode_stb_r;
    dir_t                  dir_s, dir_prev_r;
    logic [RW-1:0]         rep_cnt_r;
    logic                  left_step_r, right_step_r;

    // Glitch filter: a filtered line only moves once the whole window agrees.
    always_ff @(posedge clk25) begin
        if (clr) begin
            clk_sh_r   <= {FILTER_LEN{1'b1}};
            dat_sh_r   <= {FILTER_LEN{1'b1}};
            clk_filt_r <= 1'b1;
            dat_filt_r <= 1'b1;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sh_r   <= {clk_sh_r[FILTER_LEN-2:0], PS2C};
            dat_sh_r   <= {dat_sh_r[FILTER_LEN-2:0], PS2D};
            clk_prev_r <= clk_filt_r;
            if (&clk_sh_r)       clk_filt_r <= 1'b1;
            else if (~|clk_sh_r) clk_filt_r <= 1'b0;
            if (&dat_sh_r)       dat_filt_r <= 1'b1;
            else if (~|dat_sh_r) dat_filt_r <= 1'b0;
        end
    end

    assign fall_s     = clk_prev_r & ~clk_filt_r;
    assign timeout_s  = (state_r != ST_IDLE) && !fall_s && (idle_cnt_r >= TW'(TIMEOUT - 1));
    assign frame_ok_s = odd_ones9({parity_r, shift_r}) && dat_filt_r;

    // Frame state register.
    always_ff @(posedge clk25) begin
        if (clr) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Frame next-state logic; a timeout abandons any partial frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s && !dat_filt_r) state_nxt_s = ST_DATA;
                else                       state_nxt_s = ST_IDLE;
            end
            ST_DATA: begin
                if (timeout_s)                        state_nxt_s = ST_IDLE;
                else if (fall_s && bitcnt_r == 3'd7)  state_nxt_s = ST_PARITY;
                else                                  state_nxt_s = ST_DATA;
            end
            ST_PARITY: begin
                if (timeout_s)   state_nxt_s = ST_IDLE;
                else if (fall_s) state_nxt_s = ST_STOP;
                else             state_nxt_s = ST_PARITY;
            end
            ST_STOP: begin
                if (timeout_s || fall_s) state_nxt_s = ST_IDLE;
                else                     state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame datapath: bit assembly, inter-edge timer and result strobes.
    always_ff @(posedge clk25) begin
        if (clr) begin
            bitcnt_r     <= 3'd0;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            idle_cnt_r   <= '0;
            scan_code_r  <= 8'h00;
            scan_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            scan_valid_r <= 1'b0;
            frame_err_r  <= timeout_s;
            if (fall_s)                  idle_cnt_r <= TW'(1);
            else if (state_r == ST_IDLE) idle_cnt_r <= '0;
            else                         idle_cnt_r <= idle_cnt_r + 1'b1;
            case (state_r)
                ST_IDLE:   bitcnt_r <= 3'd0;
                ST_DATA: begin
                    if (fall_s) begin
                        shift_r  <= {dat_filt_r, shift_r[7:1]};
                        bitcnt_r <= bitcnt_r + 3'd1;
                    end
                end
                ST_PARITY: if (fall_s) parity_r <= dat_filt_r;
                ST_STOP: begin
                    if (fall_s && frame_ok_s) begin
                        scan_code_r  <= shift_r;
                        scan_valid_r <= 1'b1;
                    end else if (fall_s) begin
                        frame_err_r  <= 1'b1;
                    end
                end
                default: bitcnt_r <= 3'd0;
            endcase
        end
    end

    // Decoder: prefixes, held key bits and latched mode.
    always_ff @(posedge clk25) begin
        if (clr) begin
            brk_r        <= 1'b0;
            ext_r        <= 1'b0;
            held_left_r  <= 1'b0;
            held_right_r <= 1'b0;
            mode_r       <= 2'd0;
            mode_stb_r   <= 1'b0;
        end else begin
            mode_stb_r <= 1'b0;
            if (scan_valid_r) begin
                case (scan_code_r)
                    8'hF0: brk_r <= 1'b1;
                    8'hE0: ext_r <= 1'b1;
                    default: begin
                        brk_r <= 1'b0;
                        ext_r <= 1'b0;
                        if (!ext_r) begin
                            case (scan_code_r)
                                8'h1C: held_left_r  <= !brk_r;
                                8'h23: held_right_r <= !brk_r;
                                8'h16, 8'h1E, 8'h26: begin
                                    if (!brk_r) begin
                                        mode_r     <= key_mode(scan_code_r);
                                        mode_stb_r <= (key_mode(scan_code_r) != mode_r);
                                    end
                                end
                                default: brk_r <= 1'b0;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // Holding both keys cancels out.
    always_comb begin
        dir_s = DIR_NONE;
        if (held_left_r && !held_right_r)      dir_s = DIR_LEFT;
        else if (held_right_r && !held_left_r) dir_s = DIR_RIGHT;
        else                                   dir_s = DIR_NONE;
    end

    // Step generator: immediate pulse on a new direction, then delay/period auto-repeat.
    always_ff @(posedge clk25) begin
        if (clr) begin
            dir_prev_r   <= DIR_NONE;
            rep_cnt_r    <= '0;
            left_step_r  <= 1'b0;
            right_step_r <= 1'b0;
        end else begin
            dir_prev_r   <= dir_s;
            left_step_r  <= 1'b0;
            right_step_r <= 1'b0;
            if (dir_s != dir_prev_r) begin
                left_step_r  <= (dir_s == DIR_LEFT);
                right_step_r <= (dir_s == DIR_RIGHT);
                rep_cnt_r    <= (dir_s == DIR_NONE) ? RW'(0) : RW'(REPEAT_DELAY);
            end else if (dir_s != DIR_NONE) begin
                if (rep_cnt_r == RW'(1)) begin
                    left_step_r  <= (dir_s == DIR_LEFT);
                    right_step_r <= (dir_s == DIR_RIGHT);
                    rep_cnt_r    <= RW'(REPEAT_PERIOD);
                end else begin
                    rep_cnt_r <= rep_cnt_r - 1'b1;
                end
            end
        end
    end

    assign left_step  = left_step_r;
    assign right_step = right_step_r;
    assign mode       = mode_r;
    assign mode_stb   = mode_stb_r;
    assign scan_code  = scan_code_r;
    assign scan_valid = scan_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_input_ctrl.sv
// Bench for ps2_input_ctrl: frame table plus hand sequences, events checked through
// per-output expected/actual queues stamped with the cycle they appear in.
module tb_ps2_input_ctrl;

    localparam int F     = 8;
    localparam int T     = 100;
    localparam int D     = 20;
    localparam int P     = 5;
    localparam int LAT_SV = F + 2;
    localparam int HB    = 12;
    localparam int K_SV = 0, K_ERR = 1, K_LEFT = 2, K_RIGHT = 3, K_MODE = 4;

    logic       clk25 = 1'b0;
    logic       clr, PS2C, PS2D;
    logic       left_step, right_step, mode_stb, scan_valid, frame_err;
    logic [1:0] mode;
    logic [7:0] scan_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       stop_b;
        int         gap;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    ev_t   exp_q[5][$];
    ev_t   act_q[5][$];
    string kname[5] = '{"scan", "err", "left", "right", "mode"};

    ps2_input_ctrl #(.FILTER_LEN(F), .TIMEOUT(T), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .clk25(clk25), .clr(clr), .PS2C(PS2C), .PS2D(PS2D),
        .left_step(left_step), .right_step(right_step), .mode(mode), .mode_stb(mode_stb),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    // Monitor: stamp every output strobe with the cycle it is visible in.
    always @(negedge clk25) begin
        if (scan_valid) act_q[K_SV].push_back('{cyc, scan_code});
        if (frame_err)  act_q[K_ERR].push_back('{cyc, 8'h00});
        if (left_step)  act_q[K_LEFT].push_back('{cyc, 8'h00});
        if (right_step) act_q[K_RIGHT].push_back('{cyc, 8'h00});
        if (mode_stb)   act_q[K_MODE].push_back('{cyc, {6'd0, mode}});
        if (left_step || right_step) begin
            checks++;
            if (left_step && right_step) begin
                errors++;
                $display("FAIL step_exclusive cyc=%0d got left=1 right=1 want one of them", cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic push_exp(input int kind, input int c, input logic [7:0] v);
        exp_q[kind].push_back('{c, v});
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_left"},  {31'd0, left_step},  32'd0);
        check_val({tag, "_right"}, {31'd0, right_step}, 32'd0);
        check_val({tag, "_mode"},  {30'd0, mode},       32'd0);
        check_val({tag, "_mstb"},  {31'd0, mode_stb},   32'd0);
        check_val({tag, "_code"},  {24'd0, scan_code},  32'd0);
        check_val({tag, "_valid"}, {31'd0, scan_valid}, 32'd0);
        check_val({tag, "_err"},   {31'd0, frame_err},  32'd0);
    endtask

    // Expected step pulses from a direction start up to and including cycle last.
    task automatic expect_steps(input int kind, input int first, input int last);
        int p;
        int k;
        p = first;
        k = 0;
        while (p <= last) begin
            push_exp(kind, p, 8'h00);
            p += (k == 0) ? D : P;
            k++;
        end
    endtask

    task automatic send_bit(input logic b, output int fall_cyc);
        PS2D = b;
        tick(HB);
        PS2C = 1'b0;
        fall_cyc = cyc;
        tick(HB);
        PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop_b,
                              output int stop_fall);
        int   fc;
        logic p;
        p = (~^code) ^ bad_par;
        send_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) send_bit(code[i], fc);
        send_bit(p, fc);
        send_bit(stop_b, stop_fall);
        PS2D = 1'b1;
        tick(HB);
    endtask

    task automatic check_scoreboard(input string phase);
        ev_t e, a;
        for (int k = 0; k < 5; k++) begin
            while (exp_q[k].size() > 0 || act_q[k].size() > 0) begin
                checks++;
                if (act_q[k].size() == 0) begin
                    e = exp_q[k].pop_front();
                    errors++;
                    $display("FAIL %s_%s missing event: got none want cyc=%0d val=%0h",
                             phase, kname[k], e.cyc, e.val);
                end else if (exp_q[k].size() == 0) begin
                    a = act_q[k].pop_front();
                    errors++;
                    $display("FAIL %s_%s extra event: got cyc=%0d val=%0h want none",
                             phase, kname[k], a.cyc, a.val);
                end else begin
                    e = exp_q[k].pop_front();
                    a = act_q[k].pop_front();
                    if (e.cyc != a.cyc || e.val !== a.val) begin
                        errors++;
                        $display("FAIL %s_%s got cyc=%0d val=%0h want cyc=%0d val=%0h",
                                 phase, kname[k], a.cyc, a.val, e.cyc, e.val);
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t vecs[12];
        int   sv[12];
        int   sf, lf, fc;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 50, 1'b1, 1'b0};
        vecs[1]  = '{8'h1C, 1'b0, 1'b1, 30, 1'b1, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b1,  0, 1'b1, 1'b0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b1, 40, 1'b1, 1'b0};
        vecs[4]  = '{8'h1C, 1'b0, 1'b1, 40, 1'b1, 1'b0};
        vecs[5]  = '{8'h23, 1'b0, 1'b1, 40, 1'b1, 1'b0};
        vecs[6]  = '{8'hF0, 1'b0, 1'b1,  0, 1'b1, 1'b0};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 60, 1'b1, 1'b0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b1,  0, 1'b1, 1'b0};
        vecs[9]  = '{8'h23, 1'b0, 1'b1, 40, 1'b1, 1'b0};
        vecs[10] = '{8'h1C, 1'b1, 1'b1, 20, 1'b0, 1'b1};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 20, 1'b0, 1'b1};

        clr  = 1'b1;
        PS2C = 1'b1;
        PS2D = 1'b1;
        tick(3);
        check_idle_outputs("reset");
        clr = 1'b0;
        tick(20);

        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop_b, sf);
            sv[i] = sf + LAT_SV;
            if (vecs[i].exp_valid) push_exp(K_SV, sv[i], vecs[i].code);
            if (vecs[i].exp_err)   push_exp(K_ERR, sv[i], 8'h00);
            tick(vecs[i].gap);
        end
        expect_steps(K_LEFT,  sv[0] + 2, sv[3] + 1);
        expect_steps(K_LEFT,  sv[4] + 2, sv[5] + 1);
        expect_steps(K_RIGHT, sv[7] + 2, sv[9] + 1);
        tick(30);
        check_val("table_mode", {30'd0, mode}, 32'd0);
        check_scoreboard("table");

        // Stalled frame: start bit plus four data bits, then silence.
        send_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) send_bit(1'b1, lf);
        push_exp(K_ERR, lf + F + 1 + T, 8'h00);
        tick(T + 60);
        send_frame(8'h16, 1'b0, 1'b1, sf);
        push_exp(K_SV, sf + LAT_SV, 8'h16);
        push_exp(K_MODE, sf + LAT_SV + 1, 8'h01);
        tick(20);
        send_frame(8'h16, 1'b0, 1'b1, sf);
        push_exp(K_SV, sf + LAT_SV, 8'h16);
        tick(20);
        check_val("mode_after_16", {30'd0, mode}, 32'd1);
        check_scoreboard("timeout");

        // Extended 1C is ignored; reset lands in the middle of the next frame.
        send_frame(8'hE0, 1'b0, 1'b1, sf);
        push_exp(K_SV, sf + LAT_SV, 8'hE0);
        send_frame(8'h1C, 1'b0, 1'b1, sf);
        push_exp(K_SV, sf + LAT_SV, 8'h1C);
        tick(30);
        send_bit(1'b0, fc);
        send_bit(1'b1, fc);
        send_bit(1'b0, fc);
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        tick(1);
        check_idle_outputs("after_clr");
        tick(T + 40);
        send_frame(8'h1E, 1'b0, 1'b1, sf);
        push_exp(K_SV, sf + LAT_SV, 8'h1E);
        push_exp(K_MODE, sf + LAT_SV + 1, 8'h02);
        tick(30);
        check_val("mode_after_1E", {30'd0, mode}, 32'd2);
        check_scoreboard("clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
